// File: rtl/adc_pkg.sv
// Shared constants, output-stage state type and FIFO word packing for the ADC stream scheduler.
package adc_pkg;

  localparam int ADC_WORD_W   = 32;
  localparam int CH_ID_LSB    = 28;
  localparam int CH_ID_W      = 4;
  localparam int SEQ_LSB      = 24;
  localparam int SEQ_W        = 4;
  localparam int SAMPLE_MAX_W = 24;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } out_state_t;

  // Word layout: {ch_id[3:0], seq[3:0], sample[23:0]}
  function automatic logic [ADC_WORD_W-1:0] pack_adc_word(
    input logic [CH_ID_W-1:0]      ch_id,
    input logic [SEQ_W-1:0]        seq,
    input logic [SAMPLE_MAX_W-1:0] sample
  );
    logic [ADC_WORD_W-1:0] word;
    word = '0;
    word[CH_ID_LSB +: CH_ID_W] = ch_id;
    word[SEQ_LSB +: SEQ_W]     = seq;
    word[SAMPLE_MAX_W-1:0]     = sample;
    return word;
  endfunction

endpackage

// File: rtl/adc_stream_sched_if.sv
// FIFO push port of the ADC stream scheduler.
// A word transfers on a clock edge where fifo_push_valid and fifo_push_ready are both high;
// once valid rises, valid and data hold unchanged until that transfer (never retracted).
interface adc_stream_sched_if;
  import adc_pkg::*;

  logic                  fifo_push_valid;
  logic [ADC_WORD_W-1:0] fifo_push_data;
  logic                  fifo_push_ready;

  modport master (
    output fifo_push_valid,
    output fifo_push_data,
    input  fifo_push_ready
  );

  modport slave (
    input  fifo_push_valid,
    input  fifo_push_data,
    output fifo_push_ready
  );

endinterface

// File: rtl/adc_stream_sched_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr+1, wrapping modulo N.
module adc_stream_sched_rr_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  always_comb begin
    int c;
    logic [IDX_W-1:0] ci;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    c       = 0;
    ci      = '0;
    // Offset N comes last, so ptr itself is the lowest-priority candidate.
    for (int k = 1; k <= N; k++) begin
      c  = (int'(ptr) + k) % N;
      ci = IDX_W'(c);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        gnt_idx = ci;
      end
    end
  end

endmodule

// File: rtl/adc_stream_sched.sv
// Multi-channel ADC sample scheduler: per-channel one-word holding slots, sequence tagging,
// round-robin arbitration and a single-word output stage feeding the stream FIFO push port.
module adc_stream_sched
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int SAMPLE_W = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_enable_mask,
  input  logic [NUM_CH-1:0]          smp_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] smp_data,
  adc_stream_sched_if.master         push,
  output logic [NUM_CH-1:0]          drop_sticky,
  input  logic [NUM_CH-1:0]          drop_clear,
  output logic [15:0]                words_pushed,
  output logic                       busy,
  output out_state_t                 dbg_state
);

  localparam int IDX_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
    $fatal(1, "adc_stream_sched: NUM_CH must be 2..16");
  end
  if (SAMPLE_W < 1 || SAMPLE_W > SAMPLE_MAX_W) begin : g_bad_sample_w
    $fatal(1, "adc_stream_sched: SAMPLE_W must be 1..24");
  end

  logic [NUM_CH-1:0]   hold_vld;
  logic [SAMPLE_W-1:0] hold_data [NUM_CH];
  logic [SEQ_W-1:0]    hold_seq  [NUM_CH];
  logic [SEQ_W-1:0]    seq       [NUM_CH];
  logic [IDX_W-1:0]    rr_ptr;

  logic [NUM_CH-1:0]   arrival;
  logic [NUM_CH-1:0]   gnt;
  logic [NUM_CH-1:0]   granted;
  logic [NUM_CH-1:0]   drop;
  logic [IDX_W-1:0]    gnt_idx;
  logic                any;
  logic                arb_en;
  logic                load;

  out_state_t            state_q;
  out_state_t            state_d;
  logic [ADC_WORD_W-1:0] out_data;
  logic [SAMPLE_MAX_W-1:0] win_sample;

  assign arrival = smp_valid & ch_enable_mask & {NUM_CH{enable}};
  assign granted = gnt & {NUM_CH{arb_en}};
  // A full slot that is being granted this cycle can still accept the new sample.
  assign drop    = arrival & hold_vld & ~granted;

  adc_stream_sched_rr_pick #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (hold_vld),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld    <= '0;
      drop_sticky <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_data[i] <= '0;
        hold_seq[i]  <= '0;
        seq[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (arrival[i]) begin
          seq[i] <= seq[i] + SEQ_W'(1);
          if (!hold_vld[i] || granted[i]) begin
            hold_vld[i]  <= 1'b1;
            hold_data[i] <= smp_data[i*SAMPLE_W +: SAMPLE_W];
            hold_seq[i]  <= seq[i];
          end
        end else if (granted[i]) begin
          hold_vld[i] <= 1'b0;
        end
      end
      drop_sticky <= (drop_sticky & ~drop_clear) | drop;
    end
  end

  // Output stage: arbitrate when empty, or when the offered word is accepted this cycle.
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE:  arb_en = 1'b1;
      S_OFFER: arb_en = push.fifo_push_ready;
      default: arb_en = 1'b0;
    endcase
    if (arb_en) begin
      load    = any;
      state_d = any ? S_OFFER : S_IDLE;
    end
  end

  always_comb begin
    win_sample = '0;
    win_sample[SAMPLE_W-1:0] = hold_data[gnt_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      out_data <= '0;
      // Pointing at the last channel makes the first scan after reset start at channel 0.
      rr_ptr   <= IDX_W'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      if (load) begin
        out_data <= pack_adc_word(CH_ID_W'(gnt_idx), hold_seq[gnt_idx], win_sample);
        rr_ptr   <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_pushed <= '0;
    end else if (push.fifo_push_valid && push.fifo_push_ready) begin
      words_pushed <= words_pushed + 16'd1;
    end
  end

  assign push.fifo_push_valid = (state_q == S_OFFER);
  assign push.fifo_push_data  = out_data;
  assign busy                 = (|hold_vld) || (state_q == S_OFFER);
  assign dbg_state            = state_q;

endmodule
